// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single register-file write port between the in-order pipeline
// writeback stage and the multi-cycle MUL/DIV unit.
//   - Pipeline WB always wins the port and is never back-pressured.
//   - MUL/DIV results wait in a DEPTH-entry FIFO and drain on free cycles.
//   - A WB write to xr squashes every queued MUL/DIV entry for xr, because the
//     newer pipeline value must win.
//   - When the FIFO head has been blocked MAX_WAIT cycles in a row, PIPE_STALL
//     asks the pipeline to hold WB_EN low so the head can drain.
//   - PENDING lists destinations of valid queued entries for decode hazards.
//
// Optional feature (macro WBARB_BYPASS_EN):
//   defined   : an MD transfer that finds the FIFO empty and the port free
//               skips the FIFO and is written on the next cycle.
//   undefined : every MD transfer goes through the FIFO.
//
// Ports
//   CLK, RESET                      clock, synchronous active-high reset
//   WB_EN, WB_ADDR, WB_DATA         pipeline writeback request
//   MD_VALID, MD_READY              MUL/DIV handshake
//   MD_ADDR, MD_DATA                MUL/DIV result
//   WRITE_ENABLE/ADDRESS/DATA       registered register-file write port
//   PENDING                         bit r set while a valid entry targets xr
//   PIPE_STALL                      pipeline must keep WB_EN low while high
//   ERR                             sticky: WB_EN seen while PIPE_STALL high
//
// Handshake: an MD result transfers on a rising edge where MD_VALID and
// MD_READY are both high; MD_READY depends only on registered state, so the
// producer may hold MD_VALID and its payload until it sees the transfer.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WB_EN,
    input  logic [4:0]  WB_ADDR,
    input  logic [31:0] WB_DATA,
    input  logic        MD_VALID,
    output logic        MD_READY,
    input  logic [4:0]  MD_ADDR,
    input  logic [31:0] MD_DATA,
    output logic        WRITE_ENABLE,
    output logic [4:0]  WRITE_ADDRESS,
    output logic [31:0] WRITE_DATA,
    output logic [31:0] PENDING,
    output logic        PIPE_STALL,
    output logic        ERR
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [4:0]       addr_q [DEPTH];
    logic [4:0]       addr_d [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             ready_q, ready_d;
    logic             stall_q, stall_d;
    logic             err_q, err_d;
    logic             we_q, we_d;
    logic [4:0]       wa_q, wa_d;
    logic [31:0]      wd_q, wd_d;

    logic wb_write, head_occ, head_valid, md_fire, md_keep, bypass, push, pop;

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        vld_d    = vld_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wait_d   = wait_q;

        // x0 writes are non-writes and leave the port free
        wb_write   = WB_EN && (WB_ADDR != 5'd0);
        head_occ   = (count_q != '0);
        head_valid = head_occ && vld_q[rd_ptr_q];
        md_fire    = MD_VALID && ready_q;
        // x0 results and results overwritten by a same-cycle WB are dropped
        md_keep    = md_fire && (MD_ADDR != 5'd0) && !(wb_write && (WB_ADDR == MD_ADDR));
`ifdef WBARB_BYPASS_EN
        bypass     = md_keep && !head_occ && !wb_write;
`else
        bypass     = 1'b0;
`endif
        push       = md_keep && !bypass;
        // Any non-WB cycle retires the head, written or squashed
        pop        = head_occ && !wb_write;

        we_d = 1'b0;
        wa_d = 5'd0;
        wd_d = 32'd0;
        if (wb_write) begin
            we_d = 1'b1;
            wa_d = WB_ADDR;
            wd_d = WB_DATA;
        end else if (head_valid) begin
            we_d = 1'b1;
            wa_d = addr_q[rd_ptr_q];
            wd_d = data_q[rd_ptr_q];
        end else if (bypass) begin
            we_d = 1'b1;
            wa_d = MD_ADDR;
            wd_d = MD_DATA;
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (wb_write && (addr_q[i] == WB_ADDR)) begin
                vld_d[i] = 1'b0;
            end
        end

        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = PW'(rd_ptr_q + 1'b1);
        end
        if (push) begin
            addr_d[wr_ptr_q] = MD_ADDR;
            data_d[wr_ptr_q] = MD_DATA;
            vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d         = PW'(wr_ptr_q + 1'b1);
        end

        case ({push, pop})
            2'b10:   count_d = CW'(count_q + 1'b1);
            2'b01:   count_d = CW'(count_q - 1'b1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d < CW'(DEPTH));

        // Counter saturates at MAX_WAIT so the stall stays up until the pop
        if (pop || !head_occ) begin
            wait_d = '0;
        end else if (wb_write && head_valid && (wait_q < WW'(MAX_WAIT))) begin
            wait_d = WW'(wait_q + 1'b1);
        end
        stall_d = (wait_d >= WW'(MAX_WAIT));
        err_d   = err_q || (WB_EN && stall_q);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 5'd0;
                data_q[i] <= 32'd0;
            end
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= '0;
            ready_q  <= 1'b0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            wa_q     <= 5'd0;
            wd_q     <= 32'd0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            ready_q  <= ready_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
            we_q     <= we_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
        end
    end

    logic [31:0] pending_mask;
    always_comb begin
        pending_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                pending_mask[addr_q[i]] = 1'b1;
            end
        end
    end

    assign MD_READY      = ready_q;
    assign WRITE_ENABLE  = we_q;
    assign WRITE_ADDRESS = wa_q;
    assign WRITE_DATA    = wd_q;
    assign PENDING       = pending_mask;
    assign PIPE_STALL    = stall_q;
    assign ERR           = err_q;

endmodule
